hilo_mdu_ctrl: RTL and testbench
================================

# hilo_mdu_ctrl

Multiply/divide sequencer that owns every write into the HI/LO register pair. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO operations from the execute stage and computes products in one cycle. It runs a 32-iteration restoring divider for quotients and remainders. Results are driven as a single-cycle HI/LO write (enable plus data), and the pipeline is stalled while a divide is in flight.

## Interface
- DIV_CYCLES, 32: divider iterations; fixed at 32 for 32-bit operands, not intended to be overridden.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous and active-high.
- start_i  in  1  operation valid this cycle.
- op_i  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored (no accept).
- opA_i  in  32  rs operand (dividend / multiplicand / MTHI-MTLO source).
- opB_i  in  32  rt operand (divisor / multiplier).
- flush_i  in  1  abort in-flight or just-presented operation.
- stall_o  out  1  combinational; pipeline must hold the execute stage.
- busy_o  out  1  registered; state != IDLE.
- writeEnable_o  out  2  registered; bit1 writes HI, bit0 writes LO; single-cycle pulse.
- HI_data_o  out  32  registered HI write data.
- LO_data_o  out  32  registered LO write data.

## Operation
- States: IDLE, DIV, DONE.
- Accept: start_i && state==IDLE && !flush_i && op_i valid.
- MTHI: on accept, the next cycle presents writeEnable_o=10 and HI_data_o=opA_i. State becomes DONE.
- MTLO: same as MTHI, with writeEnable_o=01 and LO_data_o=opA_i.
- MULT/MULTU: the 64-bit product is computed combinationally (signed or unsigned) and registered. The next cycle presents writeEnable_o=11, HI=product[63:32], LO=product[31:0]. State becomes DONE.
- DIV/DIVU with opB_i!=0:
  - Latch |opA| and |opB| (raw values for DIVU) plus the sign flags; clear the counter; state goes to DIV.
  - Each DIV cycle performs one restoring step: shift the remainder/quotient pair left by 1, trial-subtract the divisor, keep the result if non-negative and set the quotient bit.
  - After the 32nd step, apply the sign fixup (DIV only): quotient negated if signA^signB; remainder negated if signA.
  - Then present writeEnable_o=11, HI=remainder, LO=quotient; state goes to DONE.
- Divide by zero (opB_i==0, DIV or DIVU): no iteration. The next cycle presents writeEnable_o=11, HI=opA_i, LO=32'hFFFFFFFF. State becomes DONE.
- Overflow case 0x80000000 / 0xFFFFFFFF (DIV) gives LO=0x80000000, HI=0 via 32-bit wrap; no special path.
- DONE: writeEnable_o high for exactly this cycle; unconditional return to IDLE. Can accept again from the following cycle (DONE itself does not accept).
- writeEnable_o is 00 in every cycle that is not a DONE cycle. HI_data_o/LO_data_o hold their last values when not writing.
- stall_o = (state==DIV) || (start_i && state==IDLE && op is DIV/DIVU && opB_i!=0 && !flush_i) || (start_i && state==DONE).
- flush_i:
  - In IDLE, it cancels any accept that cycle.
  - In DIV, state goes to IDLE next cycle, no write occurs, and the counter clears.
  - In DONE, it has no effect; the pulse is already committed.
- start_i while busy (DIV state) is ignored; stall_o guarantees it is re-presented.

## Timing
- Reset: state=IDLE, counter=0, writeEnable_o=00, HI_data_o=0, LO_data_o=0, busy_o=0. rst mid-divide aborts it with no write.
- Accept at cycle T. MTHI/MTLO/MULT/MULTU/div-by-zero write at T+1.
- Normal divide: DIV for cycles T+1..T+32, write at T+33; stall_o high T..T+32, low at T+33.
- Back-to-back: a second op held during a DONE cycle is accepted the cycle after DONE. The pipeline sees stall_o for that DONE cycle.
- busy_o high from T+1 through the write cycle inclusive.

## Test plan
- Reset: assert rst 2 cycles mid-divide -> writeEnable_o=00, HI/LO outputs 0, busy_o=0, no later write.
- MULT 0xFFFFFFFE × 0x00000003 -> at T+1 we=11, HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV 0xFFFFFFF9 (−7) / 0x00000002 -> stall_o high T..T+32, at T+33 we=11, LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
- Edge divides:
  - DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
  - DIVU 5/0 -> at T+1 HI=5, LO=0xFFFFFFFF, no stall.
- flush_i at T+10 of a divide -> IDLE at T+11, no writeEnable_o pulse ever. A new MTLO 0x1234 accepted at T+11 -> we=01, LO=0x1234 at T+12.
- Back-to-back: MTHI 0xAAAA held with start_i then MTLO 0x5555 -> we=10 at T+1; stall_o high at T+1; MTLO accepted at T+2, we=01 at T+3.

Source files
------------

// File: rtl/hilo_mdu_ctrl.sv
// HI/LO write sequencer: one-cycle multiply, MTHI/MTLO, and a 32-step restoring divider.
// All HI/LO updates leave through a registered single-cycle write port.
module hilo_mdu_ctrl #(
   parameter int DIV_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [2:0]  op_i,
   input  logic [31:0] opA_i,
   input  logic [31:0] opB_i,
   input  logic        flush_i,
   output logic        stall_o,
   output logic        busy_o,
   output logic [1:0]  writeEnable_o,
   output logic [31:0] HI_data_o,
   output logic [31:0] LO_data_o
);

   localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_DIV  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_we;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;

   logic [31:0] r_rem;
   logic [31:0] r_quo;
   logic [31:0] r_div;
   logic        r_sign_q;
   logic        r_sign_r;

   logic w_op_valid;
   logic w_is_div;
   logic w_is_sdiv;
   logic w_b_zero;
   logic w_accept;
   logic w_last;

   logic signed [63:0] w_a_s;
   logic signed [63:0] w_b_s;
   logic signed [63:0] w_prod_s;
   logic        [63:0] w_prod_u;
   logic        [63:0] w_prod;

   logic [32:0] w_trial;
   logic [31:0] w_rem_step;
   logic [31:0] w_quo_step;
   logic [31:0] w_rem_fix;
   logic [31:0] w_quo_fix;

   function automatic logic [31:0] fn_neg(input logic [31:0] v);
      return 32'(~v + 32'd1);
   endfunction

   // Magnitude of a two's-complement word; 0x80000000 maps to 2^31 read as unsigned.
   function automatic logic [31:0] fn_abs(input logic [31:0] v);
      return v[31] ? fn_neg(v) : v;
   endfunction

   assign w_op_valid = (op_i <= OP_MTLO);
   assign w_is_div   = (op_i == OP_DIV) || (op_i == OP_DIVU);
   assign w_is_sdiv  = (op_i == OP_DIV);
   assign w_b_zero   = (opB_i == 32'd0);
   assign w_accept   = start_i && (r_state == S_IDLE) && !flush_i && w_op_valid;
   assign w_last     = (r_cnt == CNT_W'(DIV_CYCLES - 1));

   assign w_a_s    = {{32{opA_i[31]}}, opA_i};
   assign w_b_s    = {{32{opB_i[31]}}, opB_i};
   assign w_prod_s = w_a_s * w_b_s;
   assign w_prod_u = {32'd0, opA_i} * {32'd0, opB_i};
   assign w_prod   = (op_i == OP_MULT) ? $unsigned(w_prod_s) : w_prod_u;

   // Restoring step: shift {rem,quo} left, trial-subtract, keep if the borrow is clear.
   assign w_trial    = {r_rem, r_quo[31]} - {1'b0, r_div};
   assign w_rem_step = w_trial[32] ? {r_rem[30:0], r_quo[31]} : w_trial[31:0];
   assign w_quo_step = {r_quo[30:0], ~w_trial[32]};
   assign w_quo_fix  = r_sign_q ? fn_neg(w_quo_step) : w_quo_step;
   assign w_rem_fix  = r_sign_r ? fn_neg(w_rem_step) : w_rem_step;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = (w_is_div && !w_b_zero) ? S_DIV : S_DONE;
         end
         S_DIV: begin
            if (flush_i)     w_state_nxt = S_IDLE;
            else if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      stall_o = 1'b0;
      busy_o  = (r_state != S_IDLE);
      if (r_state == S_DIV) stall_o = 1'b1;
      if (start_i && (r_state == S_IDLE) && w_is_div && !w_b_zero && !flush_i) stall_o = 1'b1;
      if (start_i && (r_state == S_DONE)) stall_o = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         r_we  <= 2'b00;
         r_hi  <= 32'd0;
         r_lo  <= 32'd0;
      end else begin
         r_we <= 2'b00;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_cnt <= '0;
                  case (op_i)
                     OP_MTHI: begin
                        r_we <= 2'b10;
                        r_hi <= opA_i;
                     end
                     OP_MTLO: begin
                        r_we <= 2'b01;
                        r_lo <= opA_i;
                     end
                     OP_MULT, OP_MULTU: begin
                        r_we <= 2'b11;
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                     end
                     OP_DIV, OP_DIVU: begin
                        if (w_b_zero) begin
                           r_we <= 2'b11;
                           r_hi <= opA_i;
                           r_lo <= 32'hFFFF_FFFF;
                        end
                     end
                     default: r_we <= 2'b00;
                  endcase
               end
            end
            S_DIV: begin
               if (flush_i) begin
                  r_cnt <= '0;
               end else if (w_last) begin
                  r_cnt <= '0;
                  r_we  <= 2'b11;
                  r_hi  <= w_rem_fix;
                  r_lo  <= w_quo_fix;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_cnt <= '0;
         endcase
      end
   end

   // Divider datapath carries no reset; it is always reloaded on accept.
   always_ff @(posedge clk) begin
      if (w_accept && w_is_div) begin
         r_rem    <= 32'd0;
         r_quo    <= w_is_sdiv ? fn_abs(opA_i) : opA_i;
         r_div    <= w_is_sdiv ? fn_abs(opB_i) : opB_i;
         r_sign_q <= w_is_sdiv && (opA_i[31] ^ opB_i[31]);
         r_sign_r <= w_is_sdiv && opA_i[31];
      end else if (r_state == S_DIV) begin
         r_rem <= w_rem_step;
         r_quo <= w_quo_step;
      end
   end

   assign writeEnable_o = r_we;
   assign HI_data_o     = r_hi;
   assign LO_data_o     = r_lo;

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Directed bench for hilo_mdu_ctrl: multiply, divide, div-by-zero, flush, reset and back-to-back.
module tb_hilo_mdu_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [2:0]  op_i;
   logic [31:0] opA_i;
   logic [31:0] opB_i;
   logic        flush_i;
   logic        stall_o;
   logic        busy_o;
   logic [1:0]  writeEnable_o;
   logic [31:0] HI_data_o;
   logic [31:0] LO_data_o;

   int checks = 0;
   int errors = 0;

   hilo_mdu_ctrl #(.DIV_CYCLES(32)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .opA_i(opA_i), .opB_i(opB_i),
      .flush_i(flush_i), .stall_o(stall_o), .busy_o(busy_o), .writeEnable_o(writeEnable_o),
      .HI_data_o(HI_data_o), .LO_data_o(LO_data_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      start_i = 1'b1;
      op_i    = op;
      opA_i   = a;
      opB_i   = b;
   endtask

   task automatic test_reset_initial();
      checks++;
      if (writeEnable_o !== 2'b00 || HI_data_o !== 32'd0 || LO_data_o !== 32'd0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_init we=%b hi=%h lo=%h busy=%b want we=00 hi=0 lo=0 busy=0",
                  writeEnable_o, HI_data_o, LO_data_o, busy_o);
      end
   endtask

   task automatic test_mult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      present(op, a, b);
      #1;
      checks++;
      if (stall_o !== 1'b0) begin
         errors++;
         $display("FAIL mult_stall_T op=%0d stall=%b want 0", op, stall_o);
      end
      step();
      start_i = 1'b0;
      #1;
      checks++;
      if (writeEnable_o !== 2'b11 || HI_data_o !== exp_hi || LO_data_o !== exp_lo || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL mult_result op=%0d we=%b hi=%h lo=%h busy=%b want we=11 hi=%h lo=%h busy=1",
                  op, writeEnable_o, HI_data_o, LO_data_o, busy_o, exp_hi, exp_lo);
      end
      step();
      checks++;
      if (writeEnable_o !== 2'b00 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL mult_after op=%0d we=%b busy=%b want we=00 busy=0", op, writeEnable_o, busy_o);
      end
   endtask

   task automatic test_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int bad;
      present(op, a, b);
      #1;
      checks++;
      if (stall_o !== 1'b1) begin
         errors++;
         $display("FAIL div_stall_T a=%h b=%h stall=%b want 1", a, b, stall_o);
      end
      bad = 0;
      for (int k = 1; k <= 32; k++) begin
         step();
         start_i = 1'b0;
         #1;
         if (stall_o !== 1'b1 || writeEnable_o !== 2'b00 || busy_o !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL div_inflight a=%h b=%h bad_cycles=%0d want 0", a, b, bad);
      end
      step();
      checks++;
      if (stall_o !== 1'b0 || writeEnable_o !== 2'b11 || HI_data_o !== exp_hi ||
          LO_data_o !== exp_lo || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL div_result op=%0d a=%h b=%h stall=%b we=%b hi=%h lo=%h want stall=0 we=11 hi=%h lo=%h",
                  op, a, b, stall_o, writeEnable_o, HI_data_o, LO_data_o, exp_hi, exp_lo);
      end
      step();
      checks++;
      if (writeEnable_o !== 2'b00 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL div_after we=%b busy=%b want we=00 busy=0", writeEnable_o, busy_o);
      end
   endtask

   task automatic test_div_zero(input logic [2:0] op, input logic [31:0] a);
      present(op, a, 32'd0);
      #1;
      checks++;
      if (stall_o !== 1'b0) begin
         errors++;
         $display("FAIL divzero_stall stall=%b want 0", stall_o);
      end
      step();
      start_i = 1'b0;
      checks++;
      if (writeEnable_o !== 2'b11 || HI_data_o !== a || LO_data_o !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL divzero_result we=%b hi=%h lo=%h want we=11 hi=%h lo=ffffffff",
                  writeEnable_o, HI_data_o, LO_data_o, a);
      end
      step();
   endtask

   task automatic test_ignored();
      present(3'b110, 32'h1111_1111, 32'h2222_2222);
      step();
      start_i = 1'b0;
      checks++;
      if (writeEnable_o !== 2'b00 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL invalid_op we=%b busy=%b want we=00 busy=0", writeEnable_o, busy_o);
      end
      present(3'b000, 32'd5, 32'd6);
      flush_i = 1'b1;
      step();
      start_i = 1'b0;
      flush_i = 1'b0;
      checks++;
      if (writeEnable_o !== 2'b00 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL idle_flush we=%b busy=%b want we=00 busy=0", writeEnable_o, busy_o);
      end
   endtask

   task automatic test_flush();
      int bad;
      present(3'b011, 32'd100, 32'd7);
      bad = 0;
      for (int k = 1; k <= 10; k++) begin
         step();
         start_i = 1'b0;
         if (writeEnable_o !== 2'b00) bad++;
      end
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      #1;
      checks++;
      if (busy_o !== 1'b0 || stall_o !== 1'b0 || writeEnable_o !== 2'b00 || bad != 0) begin
         errors++;
         $display("FAIL flush_idle busy=%b stall=%b we=%b early_writes=%0d want busy=0 stall=0 we=00 0",
                  busy_o, stall_o, writeEnable_o, bad);
      end
      present(3'b101, 32'h0000_1234, 32'd0);
      step();
      start_i = 1'b0;
      checks++;
      if (writeEnable_o !== 2'b01 || LO_data_o !== 32'h0000_1234) begin
         errors++;
         $display("FAIL flush_mtlo we=%b lo=%h want we=01 lo=00001234", writeEnable_o, LO_data_o);
      end
      bad = 0;
      for (int k = 0; k < 30; k++) begin
         step();
         if (writeEnable_o !== 2'b00) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL flush_late_write pulses=%0d want 0", bad);
      end
   endtask

   task automatic test_reset_mid_divide();
      int bad;
      present(3'b001, 32'hFFFF_FFFE, 32'd3);
      step();
      start_i = 1'b0;
      step();
      present(3'b011, 32'd100, 32'd7);
      for (int k = 0; k < 5; k++) begin
         step();
         start_i = 1'b0;
      end
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
      checks++;
      if (writeEnable_o !== 2'b00 || HI_data_o !== 32'd0 || LO_data_o !== 32'd0 ||
          busy_o !== 1'b0 || stall_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid we=%b hi=%h lo=%h busy=%b stall=%b want 00 0 0 0 0",
                  writeEnable_o, HI_data_o, LO_data_o, busy_o, stall_o);
      end
      bad = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (writeEnable_o !== 2'b00) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL reset_late_write pulses=%0d want 0", bad);
      end
   endtask

   task automatic test_back_to_back();
      present(3'b100, 32'h0000_AAAA, 32'd0);
      #1;
      checks++;
      if (stall_o !== 1'b0) begin
         errors++;
         $display("FAIL b2b_stall_T stall=%b want 0", stall_o);
      end
      step();
      present(3'b101, 32'h0000_5555, 32'd0);
      #1;
      checks++;
      if (writeEnable_o !== 2'b10 || HI_data_o !== 32'h0000_AAAA || stall_o !== 1'b1) begin
         errors++;
         $display("FAIL b2b_mthi we=%b hi=%h stall=%b want we=10 hi=0000aaaa stall=1",
                  writeEnable_o, HI_data_o, stall_o);
      end
      step();
      checks++;
      if (writeEnable_o !== 2'b00 || stall_o !== 1'b0) begin
         errors++;
         $display("FAIL b2b_gap we=%b stall=%b want we=00 stall=0", writeEnable_o, stall_o);
      end
      step();
      start_i = 1'b0;
      checks++;
      if (writeEnable_o !== 2'b01 || LO_data_o !== 32'h0000_5555 || HI_data_o !== 32'h0000_AAAA) begin
         errors++;
         $display("FAIL b2b_mtlo we=%b lo=%h hi=%h want we=01 lo=00005555 hi=0000aaaa",
                  writeEnable_o, LO_data_o, HI_data_o);
      end
      step();
   endtask

   initial begin
      rst     = 1'b1;
      start_i = 1'b0;
      op_i    = 3'b000;
      opA_i   = 32'd0;
      opB_i   = 32'd0;
      flush_i = 1'b0;
      step();
      step();
      rst = 1'b0;
      test_reset_initial();
      test_mult(3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      test_mult(3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA);
      test_div(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      test_div(3'b011, 32'd100, 32'd7, 32'd2, 32'd14);
      test_div(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      test_div(3'b010, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
      test_div(3'b011, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC);
      test_div_zero(3'b011, 32'd5);
      test_div_zero(3'b010, 32'hFFFF_FFF9);
      test_ignored();
      test_flush();
      test_back_to_back();
      test_reset_mid_divide();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
